// File: rtl/idx_stream_gen.sv
// idx_stream_gen: arithmetic sequencer emitting packed (optionally bit-reversed) index words
// Revision 1.0
`default_nettype none

module idx_stream_gen #(
    parameter int LANES = 2,
    parameter int IDX_W = 8,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [IDX_W-1:0]       base,
    input  logic [IDX_W-1:0]       stride,
    input  logic [CNT_W-1:0]       count,
    input  logic                   bitrev,
    output logic [LANES*IDX_W-1:0] dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   dout_last,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   acc;
    logic [IDX_W-1:0]   stride_r;
    logic               bitrev_r;
    logic [CNT_W-1:0]   left;
    logic               load_first;
    logic               load_next;
    logic               finish;

    logic [IDX_W-1:0]       src_base;
    logic [IDX_W-1:0]       src_stride;
    logic                   src_rev;
    logic [IDX_W-1:0]       chain [0:LANES];
    logic [LANES*IDX_W-1:0] word;

    function automatic logic [IDX_W-1:0] rev_bits(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] r;
        for (int i = 0; i < IDX_W; i++) begin
            r[i] = v[IDX_W-1-i];
        end
        return r;
    endfunction

    // In IDLE the first word is built straight from the live inputs;
    // afterwards from the latched configuration and accumulator.
    assign src_base   = (state == S_IDLE) ? base   : acc;
    assign src_stride = (state == S_IDLE) ? stride : stride_r;
    assign src_rev    = (state == S_IDLE) ? bitrev : bitrev_r;

    // Adder chain: lane j = lane j-1 + stride; the last tap is the next lane-0 value.
    assign chain[0] = src_base;

    for (genvar j = 1; j <= LANES; j++) begin : g_chain
        assign chain[j] = chain[j-1] + src_stride;
    end

    for (genvar j = 0; j < LANES; j++) begin : g_pack
        assign word[(LANES-j)*IDX_W-1 -: IDX_W] = src_rev ? rev_bits(chain[j]) : chain[j];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        done       = 1'b0;
        load_first = 1'b0;
        load_next  = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        state_nxt = S_FIN;
                    end else begin
                        state_nxt  = S_RUN;
                        load_first = 1'b1;
                    end
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt = S_FIN;
                    finish    = 1'b1;
                end else if (dout_valid && dout_ready) begin
                    if (left == '0) begin
                        state_nxt = S_FIN;
                        finish    = 1'b1;
                    end else begin
                        load_next = 1'b1;
                    end
                end
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            stride_r   <= '0;
            bitrev_r   <= 1'b0;
            left       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                stride_r <= stride;
                bitrev_r <= bitrev;
            end
            if (load_first) begin
                dout       <= word;
                dout_valid <= 1'b1;
                dout_last  <= (count == CNT_W'(1));
                left       <= count - CNT_W'(1);
                acc        <= chain[LANES];
            end else if (load_next) begin
                dout      <= word;
                dout_last <= (left == CNT_W'(1));
                left      <= left - CNT_W'(1);
                acc       <= chain[LANES];
            end else if (finish) begin
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_idx_stream_gen.sv
// Testbench for idx_stream_gen: scoreboard of expected words against the streamed output.
`default_nettype none

module tb_idx_stream_gen;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [7:0]  base;
    logic [7:0]  stride;
    logic [7:0]  count;
    logic        bitrev;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;
    logic [16:0] exp_q [$];

    idx_stream_gen #(.LANES(2), .IDX_W(8), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .base       (base),
        .stride     (stride),
        .count      (count),
        .bitrev     (bitrev),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model_word(input logic [7:0] b, input logic [7:0] s,
                                               input int k, input bit r);
        logic [7:0]  raw;
        logic [7:0]  o;
        logic [15:0] w;
        w = '0;
        for (int j = 0; j < 2; j++) begin
            raw = 8'(b + s * 8'(k * 2 + j));
            for (int i = 0; i < 8; i++) o[i] = r ? raw[7-i] : raw[i];
            w[15-8*j -: 8] = o;
        end
        return w;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic do_start(input logic [7:0] b, input logic [7:0] s, input logic [7:0] c,
                            input bit r);
        start = 1'b1; base = b; stride = s; count = c; bitrev = r;
        for (int k = 0; k < int'(c); k++) exp_q.push_back({(k == int'(c) - 1), model_word(b, s, k, r)});
        @(negedge clk);
        start = 1'b0;
        base = 8'($urandom); stride = 8'($urandom); count = 8'($urandom); bitrev = 1'($urandom);
    endtask

    // Consumes the stream against the scoreboard, then checks the done pulse.
    task automatic drain(input int max_cycles, input bit rnd_ready, output int hs_cnt);
        int          cyc;
        bit          stalled;
        logic [16:0] prev;
        logic [16:0] e;
        cyc = 0; stalled = 0; hs_cnt = 0; prev = '0;
        while (exp_q.size() > 0 && cyc < max_cycles) begin
            if (stalled) begin
                n_checks++;
                if (dout_valid !== 1'b1 || {dout_last, dout} !== prev) begin
                    $display("FAIL stall_hold: valid=%b word=%h required valid=1 word=%h",
                             dout_valid, {dout_last, dout}, prev);
                end else n_pass++;
            end
            dout_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (dout_valid && dout_ready) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({dout_last, dout} !== e) begin
                    $display("FAIL stream_word: got last=%b dout=%h required last=%b dout=%h",
                             dout_last, dout, e[16], e[15:0]);
                end else n_pass++;
                hs_cnt++;
                stalled = 0;
            end else if (dout_valid) begin
                stalled = 1;
                prev = {dout_last, dout};
            end
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL stream_timeout: %0d words outstanding, required 0", exp_q.size());
            exp_q.delete();
        end else n_pass++;
        n_checks++;
        if (done !== 1'b1 || dout_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL done_pulse: done=%b valid=%b busy=%b required 1/0/0", done, dout_valid, busy);
        end else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) $display("FAIL done_width: done=%b required 0", done);
        else n_pass++;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({dout, dout_valid, dout_last, busy, done} !== 20'h0) begin
            $display("FAIL reset_outputs: dout=%h valid=%b last=%b busy=%b done=%b required all 0",
                     dout, dout_valid, dout_last, busy, done);
        end else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_linear();
        int hs;
        do_start(8'h00, 8'h01, 8'd128, 1'b0);
        n_checks++;
        if (dout_valid !== 1'b1 || busy !== 1'b1 || dout !== 16'h0001) begin
            $display("FAIL first_word_latency: valid=%b busy=%b dout=%h required 1/1/0001",
                     dout_valid, busy, dout);
        end else n_pass++;
        drain(400, 1'b0, hs);
        n_checks++;
        if (hs != 128) $display("FAIL linear_count: got %0d handshakes required 128", hs);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int hs;
        do_start(8'hF0, 8'h04, 8'd6, 1'b0);
        drain(50, 1'b0, hs);
    endtask

    task automatic test_bitrev();
        int hs;
        do_start(8'h00, 8'h01, 8'd4, 1'b1);
        drain(50, 1'b0, hs);
    endtask

    task automatic test_zero_count();
        do_start(8'h12, 8'h03, 8'd0, 1'b0);
        n_checks++;
        if (dout_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
            $display("FAIL zero_count: valid=%b busy=%b done=%b required 0/0/1", dout_valid, busy, done);
        end else n_pass++;
        @(negedge clk);
        n_checks++;
        if (dout_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL zero_count_after: valid=%b busy=%b done=%b required 0/0/0", dout_valid, busy, done);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        int hs;
        do_start(8'h37, 8'h05, 8'd20, 1'b0);
        // Second start while busy, with the word stalled so it cannot advance.
        dout_ready = 1'b0;
        start = 1'b1; base = 8'h55; stride = 8'h11; count = 8'd3; bitrev = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (dout !== model_word(8'h37, 8'h05, 0, 1'b0) || busy !== 1'b1) begin
            $display("FAIL start_while_busy: dout=%h busy=%b required %h/1",
                     dout, busy, model_word(8'h37, 8'h05, 0, 1'b0));
        end else n_pass++;
        drain(400, 1'b1, hs);
        n_checks++;
        if (hs != 20) $display("FAIL backpressure_count: got %0d handshakes required 20", hs);
        else n_pass++;
    endtask

    task automatic test_abort();
        int hs;
        dout_ready = 1'b1;
        do_start(8'h10, 8'h02, 8'd8, 1'b0);
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (dout_valid !== 1'b1 || dout !== model_word(8'h10, 8'h02, k, 1'b0)) begin
                $display("FAIL abort_pre_word: k=%0d valid=%b dout=%h required 1/%h",
                         k, dout_valid, dout, model_word(8'h10, 8'h02, k, 1'b0));
            end else n_pass++;
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (dout_valid !== 1'b0 || dout_last !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL abort_stop: valid=%b last=%b done=%b busy=%b required 0/0/1/0",
                     dout_valid, dout_last, done, busy);
        end else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || dout_valid !== 1'b0) begin
            $display("FAIL abort_idle: done=%b valid=%b required 0/0", done, dout_valid);
        end else n_pass++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL abort_in_idle: done=%b busy=%b required 0/0", done, busy);
        end else n_pass++;
        do_start(8'h40, 8'h01, 8'd2, 1'b0);
        drain(20, 1'b0, hs);
    endtask

    task automatic test_async_reset();
        dout_ready = 1'b0;
        do_start(8'h20, 8'h01, 8'd10, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({dout, dout_valid, dout_last, busy, done} !== 20'h0) begin
            $display("FAIL async_reset: dout=%h valid=%b last=%b busy=%b done=%b required all 0",
                     dout, dout_valid, dout_last, busy, done);
        end else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || dout_valid !== 1'b0) begin
            $display("FAIL reset_no_done: done=%b busy=%b valid=%b required 0/0/0", done, busy, dout_valid);
        end else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; base = '0; stride = '0;
        count = '0; bitrev = 1'b0; dout_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_linear();
        test_wrap();
        test_bitrev();
        test_zero_count();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
